// File: rtl/alu_cmd_queue.sv
// Command FIFO in front of a fixed-latency ALU: issues one command at a time, captures the
// result after ALU_LAT edges and holds it on a valid/ready result port until consumed.
module alu_cmd_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned IN_W    = 5,
  parameter int unsigned OP_W    = 3,
  parameter int unsigned OUT_W   = 9,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [IN_W-1:0]            cmd_in1,
  input  logic [IN_W-1:0]            cmd_in2,
  input  logic [OP_W-1:0]            cmd_opcode,
  output logic [IN_W-1:0]            alu_in1,
  output logic [IN_W-1:0]            alu_in2,
  output logic [OP_W-1:0]            alu_opcode,
  input  logic [OUT_W-1:0]           alu_out,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [OUT_W-1:0]           res_data,
  output logic [OP_W-1:0]            res_opcode,
  output logic                       res_divz,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned CMD_W = 2 * IN_W + OP_W;
  localparam int unsigned CTR_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);
  localparam logic [CTR_W-1:0] LatLoad = CTR_W'(ALU_LAT);
  localparam logic [OP_W-1:0]  OpDiv   = OP_W'(3);

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  state_e           state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  logic             push, pop, capture, res_clear;
  logic [CMD_W-1:0] head;
  logic [IN_W-1:0]  head_in1, head_in2;
  logic [OP_W-1:0]  head_op;

  logic [IN_W-1:0]  alu_in1_q, alu_in2_q;
  logic [OP_W-1:0]  alu_opcode_q;
  logic             divz_pend_q;

  logic             res_valid_q;
  logic [OUT_W-1:0] res_data_q;
  logic [OP_W-1:0]  res_opcode_q;
  logic             res_divz_q;

  // Ready depends only on registered occupancy; a pop in the same cycle does not free a slot.
  assign cmd_ready = (count_q != FullCnt);
  assign push      = cmd_valid && cmd_ready;

  assign head     = mem_q[rd_ptr_q];
  assign head_in1 = head[CMD_W-1 -: IN_W];
  assign head_in2 = head[OP_W +: IN_W];
  assign head_op  = head[OP_W-1:0];

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_in1, cmd_in2, cmd_opcode};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    pop       = 1'b0;
    capture   = 1'b0;
    res_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          ctr_d   = LatLoad;
          state_d = StWait;
        end
      end
      StWait: begin
        if (ctr_q == '0) begin
          capture = 1'b1;
          state_d = StHold;
        end else begin
          ctr_d = ctr_q - CTR_W'(1);
        end
      end
      StHold: begin
        if (res_valid_q && res_ready) begin
          res_clear = 1'b1;
          // Back-to-back issue keeps the stream at one result per ALU_LAT+2 cycles.
          if (count_q != '0) begin
            pop     = 1'b1;
            ctr_d   = LatLoad;
            state_d = StWait;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      alu_opcode_q <= '0;
      divz_pend_q  <= 1'b0;
    end else if (pop) begin
      alu_in1_q    <= head_in1;
      alu_in2_q    <= head_in2;
      alu_opcode_q <= head_op;
      divz_pend_q  <= (head_op == OpDiv) && (head_in2 == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_opcode_q <= '0;
      res_divz_q   <= 1'b0;
    end else if (capture) begin
      res_valid_q  <= 1'b1;
      // Divide-by-zero ignores whatever the ALU produced.
      res_data_q   <= divz_pend_q ? '0 : alu_out;
      res_opcode_q <= alu_opcode_q;
      res_divz_q   <= divz_pend_q;
    end else if (res_clear) begin
      res_valid_q <= 1'b0;
    end
  end

  assign alu_in1    = alu_in1_q;
  assign alu_in2    = alu_in2_q;
  assign alu_opcode = alu_opcode_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_opcode = res_opcode_q;
  assign res_divz   = res_divz_q;
  assign count      = count_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed bench for alu_cmd_queue with a one-cycle-latency ALU model on the alu_* side.
module tb_alu_cmd_queue;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic signed [4:0] cmd_in1 = '0;
  logic signed [4:0] cmd_in2 = '0;
  logic [2:0]        cmd_opcode = '0;
  logic signed [4:0] alu_in1, alu_in2;
  logic [2:0]        alu_opcode;
  logic signed [8:0] alu_out = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic signed [8:0] res_data;
  logic [2:0]        res_opcode;
  logic              res_divz;
  logic [2:0]        count;

  int vectors = 0;
  int miscompares = 0;

  alu_cmd_queue dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_in1    (cmd_in1),
    .cmd_in2    (cmd_in2),
    .cmd_opcode (cmd_opcode),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_opcode (res_opcode),
    .res_divz   (res_divz),
    .count      (count)
  );

  always #5 clk = ~clk;

  // ALU stand-in; divide-by-zero yields a junk value the queue must suppress.
  function automatic logic signed [8:0] alu_f(input logic signed [4:0] a, input logic signed [4:0] b,
                                              input logic [2:0] op);
    logic signed [8:0] x, y;
    x = a;
    y = b;
    case (op)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x * y;
      3'd3: return (y == 0) ? 9'sd77 : x / y;
      3'd4: return x | y;
      3'd5: return x & y;
      3'd6: return ~(x & y);
      default: return ~(x | y);
    endcase
  endfunction

  always @(posedge clk) alu_out <= alu_f(alu_in1, alu_in2, alu_opcode);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required summary before limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input int a, input int b, input int op);
    cmd_in1    = 5'(a);
    cmd_in2    = 5'(b);
    cmd_opcode = 3'(op);
    cmd_valid  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        tick();
        cmd_valid = 1'b0;
        return;
      end
      tick();
    end
    cmd_valid = 1'b0;
    vectors++;
    miscompares++;
    $display("FAIL push_timeout: cmd_ready stayed 0, required 1 within 50 cycles");
  endtask

  task automatic wait_res(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!res_valid && n < 50);
    if (!res_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL res_timeout: res_valid stayed 0, required 1 within 50 cycles");
    end
  endtask

  task automatic accept_res();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if (count !== 3'd0 || cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: count=%0d ready=%b valid=%b, required 0/1/0", count, cmd_ready,
               res_valid);
    end
    vectors++;
    if (res_data !== 9'sd0 || res_opcode !== 3'd0 || res_divz !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_res: data=%0d op=%0d divz=%b, required 0/0/0", res_data, res_opcode,
               res_divz);
    end
    vectors++;
    if (alu_in1 !== 5'sd0 || alu_in2 !== 5'sd0 || alu_opcode !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_alu: in1=%0d in2=%0d op=%0d, required 0/0/0", alu_in1, alu_in2,
               alu_opcode);
    end
  endtask

  task automatic test_single();
    int n;
    push_cmd(2, 3, 0);
    tick();
    vectors++;
    if (alu_in1 !== 5'sd2 || alu_in2 !== 5'sd3 || alu_opcode !== 3'd0) begin
      miscompares++;
      $display("FAIL issue_alu: in1=%0d in2=%0d op=%0d, required 2/3/0", alu_in1, alu_in2,
               alu_opcode);
    end
    wait_res(n);
    vectors++;
    if (n + 1 !== 3) begin
      miscompares++;
      $display("FAIL single_latency: %0d edges, required 3", n + 1);
    end
    vectors++;
    if (res_data !== 9'sd5 || res_opcode !== 3'd0 || res_divz !== 1'b0) begin
      miscompares++;
      $display("FAIL single_res: data=%0d op=%0d divz=%b, required 5/0/0", res_data, res_opcode,
               res_divz);
    end
    accept_res();
    vectors++;
    if (res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_clear: res_valid=%b, required 0", res_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [8:0] ed [3] = '{-9'sd8, 9'sd10, -9'sd2};
    logic [2:0]        eo [3] = '{3'd1, 3'd2, 3'd4};
    int cyc [3];
    int n = 0;
    res_ready = 1'b1;
    push_cmd(-2, 6, 1);
    push_cmd(2, 5, 2);
    push_cmd(6, -6, 4);
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (res_valid) begin
        if (n < 3) begin
          vectors++;
          if (res_data !== ed[n] || res_opcode !== eo[n] || res_divz !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_res%0d: data=%0d op=%0d divz=%b, required %0d/%0d/0", n, res_data,
                     res_opcode, res_divz, ed[n], eo[n]);
          end
          cyc[n] = c;
        end
        n++;
      end
    end
    res_ready = 1'b0;
    vectors++;
    if (n !== 3) begin
      miscompares++;
      $display("FAIL b2b_count: %0d results, required 3", n);
    end else begin
      vectors++;
      if (cyc[1] - cyc[0] !== 3 || cyc[2] - cyc[1] !== 3) begin
        miscompares++;
        $display("FAIL b2b_spacing: gaps %0d,%0d, required 3,3", cyc[1] - cyc[0], cyc[2] - cyc[1]);
      end
    end
  endtask

  task automatic test_divz();
    int n;
    push_cmd(12, 0, 3);
    wait_res(n);
    vectors++;
    if (res_data !== 9'sd0 || res_divz !== 1'b1 || res_opcode !== 3'd3) begin
      miscompares++;
      $display("FAIL divz_zero: data=%0d divz=%b op=%0d, required 0/1/3", res_data, res_divz,
               res_opcode);
    end
    accept_res();
    push_cmd(12, 4, 3);
    wait_res(n);
    vectors++;
    if (res_data !== 9'sd3 || res_divz !== 1'b0 || res_opcode !== 3'd3) begin
      miscompares++;
      $display("FAIL divz_normal: data=%0d divz=%b op=%0d, required 3/0/3", res_data, res_divz,
               res_opcode);
    end
    accept_res();
  endtask

  task automatic test_full();
    logic signed [8:0] ed [6] = '{9'sd2, 9'sd1, -9'sd9, -9'sd4, 9'sd1, -9'sd8};
    logic [2:0]        eo [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd7};
    int n = 0;
    logic hs, acc, acc6;
    logic signed [8:0] d;
    logic [2:0] o;
    res_ready = 1'b0;
    push_cmd(1, 1, 0);
    push_cmd(3, 2, 1);
    push_cmd(-3, 3, 2);
    push_cmd(-8, 2, 3);
    push_cmd(5, 3, 5);
    vectors++;
    if (count !== 3'd4 || cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_state: count=%0d ready=%b, required 4/0", count, cmd_ready);
    end
    cmd_in1 = 5'sd5;
    cmd_in2 = 5'sd3;
    cmd_opcode = 3'd7;
    cmd_valid = 1'b1;
    tick();
    tick();
    tick();
    vectors++;
    if (count !== 3'd4 || cmd_ready !== 1'b0 || res_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL full_held: count=%0d ready=%b valid=%b, required 4/0/1", count, cmd_ready,
               res_valid);
    end
    res_ready = 1'b1;
    acc6 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      hs  = res_valid && res_ready;
      d   = res_data;
      o   = res_opcode;
      acc = cmd_valid && cmd_ready;
      tick();
      if (acc) begin
        cmd_valid = 1'b0;
        acc6 = 1'b1;
      end
      if (hs) begin
        if (n < 6) begin
          vectors++;
          if (d !== ed[n] || o !== eo[n]) begin
            miscompares++;
            $display("FAIL full_res%0d: data=%0d op=%0d, required %0d/%0d", n, d, o, ed[n], eo[n]);
          end
        end
        n++;
      end
    end
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    vectors++;
    if (n !== 6 || acc6 !== 1'b1) begin
      miscompares++;
      $display("FAIL full_count: %0d results, sixth accepted=%b, required 6/1", n, acc6);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int seen = 0;
    res_ready = 1'b0;
    push_cmd(1, 2, 0);
    wait_res(n);
    push_cmd(1, 1, 0);
    push_cmd(2, 2, 0);
    push_cmd(3, 3, 0);
    push_cmd(4, 4, 0);
    accept_res();
    vectors++;
    if (count !== 3'd3 || res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_setup: count=%0d valid=%b, required 3/0", count, res_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (count !== 3'd0 || res_valid !== 1'b0 || alu_in1 !== 5'sd0 || alu_in2 !== 5'sd0 ||
        alu_opcode !== 3'd0) begin
      miscompares++;
      $display("FAIL mid_reset: count=%0d valid=%b alu=%0d/%0d/%0d, required 0/0/0/0/0", count,
               res_valid, alu_in1, alu_in2, alu_opcode);
    end
    res_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (res_valid) seen++;
    end
    res_ready = 1'b0;
    vectors++;
    if (seen !== 0 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL mid_quiet: %0d results, count=%0d, required 0/0", seen, count);
    end
  endtask

  task automatic test_hold_stable();
    logic signed [8:0] ed [3] = '{9'sd3, 9'sd0, 9'sd6};
    logic [2:0]        eo [3] = '{3'd3, 3'd3, 3'd6};
    logic              ez [3] = '{1'b0, 1'b1, 1'b0};
    int idx = 0;
    logic hs, stall;
    res_ready = 1'b0;
    push_cmd(7, 2, 3);
    push_cmd(4, 0, 3);
    push_cmd(-5, -3, 6);
    for (int c = 0; c < 100; c++) begin
      res_ready = (c < 60) ? 1'($urandom_range(0, 1)) : 1'b1;
      hs    = res_valid && res_ready;
      stall = res_valid && !res_ready;
      tick();
      if (hs) idx++;
      if (stall) begin
        vectors++;
        if (res_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL hold_valid: res_valid=%b while stalled, required 1", res_valid);
        end
      end
      if (res_valid && idx < 3) begin
        vectors++;
        if (res_data !== ed[idx] || res_opcode !== eo[idx] || res_divz !== ez[idx]) begin
          miscompares++;
          $display("FAIL hold_res%0d: data=%0d op=%0d divz=%b, required %0d/%0d/%b", idx,
                   res_data, res_opcode, res_divz, ed[idx], eo[idx], ez[idx]);
        end
      end
    end
    res_ready = 1'b0;
    vectors++;
    if (idx !== 3) begin
      miscompares++;
      $display("FAIL hold_count: %0d results consumed, required 3", idx);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_divz();
    test_full();
    test_reset_mid();
    test_hold_stable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
